// File: rtl/tff_pkg.sv
// tff_pkg
// Shared definitions for the T-flip-flop modulo counter: default and legal
// parameter ranges, plus the wrap-aware next-count function.
// Counts are carried in a fixed 16-bit container (the widest legal counter).
// The modulus is passed as MOD-1 so that MOD = 2**16 still fits.
package tff_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int MOD_DEF   = 10;
    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;
    localparam int MOD_MIN   = 2;

    typedef logic [WIDTH_MAX-1:0] cnt_t;

    // Next enabled count in the given direction.
    // An out-of-range count (q > mod_m1) always recovers to zero.
    function automatic cnt_t next_count(input cnt_t q, input logic up, input cnt_t mod_m1);
        cnt_t nxt;
        if (q > mod_m1) begin
            nxt = '0;
        end else if (up) begin
            nxt = (q == mod_m1) ? '0 : q + cnt_t'(1);
        end else begin
            nxt = (q == '0) ? mod_m1 : q - cnt_t'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tff_stage.sv
// tff_stage
// One T-type storage bit. The bit flips on a rising edge of Clk when T is 1.
// Ports:
//   Clk     - clock, rising edge
//   Reset_n - asynchronous active-low reset, clears Q
//   T       - toggle request for the next edge
//   Q       - stored bit
//   Q_bar   - complement of Q
module tff_stage (
    input  logic Clk,
    input  logic Reset_n,
    input  logic T,
    output logic Q,
    output logic Q_bar
);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Q <= 1'b0;
        end else begin
            Q <= Q ^ T;
        end
    end

    assign Q_bar = ~Q;

endmodule

// File: rtl/tff_mod_counter.sv
// tff_mod_counter
// Up/down modulo-MOD counter whose state is held in one T flip-flop per bit.
// The top level chooses the next count, converts it into a toggle vector,
// and produces the terminal-count and sticky wrap flags.
//
// Optional feature macro: TFF_CNT_LOAD_EN adds the Load/Din parallel load,
// clamped to MOD-1. Without it the priority is Clr > En > hold.
//
// Ports:
//   Clk     - clock, rising edge
//   Reset_n - asynchronous active-low reset
//   En      - count enable
//   Up      - direction, 1 = increment, 0 = decrement
//   Clr     - synchronous clear to zero (highest priority)
//   Load    - synchronous load (TFF_CNT_LOAD_EN only)
//   Din     - load value (TFF_CNT_LOAD_EN only)
//   Q       - current count
//   Q_bar   - bitwise complement of Q
//   T       - toggle vector applied at the next edge
//   Tc      - terminal count: this edge wraps
//   Ovf     - sticky wrap flag, cleared by Clr or reset
module tff_mod_counter
    import tff_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int MOD   = MOD_DEF
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             Up,
    input  logic             Clr,
`ifdef TFF_CNT_LOAD_EN
    input  logic             Load,
    input  logic [WIDTH-1:0] Din,
`endif
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic [WIDTH-1:0] T,
    output logic             Tc,
    output logic             Ovf
);

    localparam cnt_t             MOD_M1   = cnt_t'(MOD - 1);
    localparam logic [WIDTH-1:0] MOD_M1_W = WIDTH'(MOD - 1);

    logic             load_act;
    logic [WIDTH-1:0] q_next;
    cnt_t             cnt_nxt;

`ifdef TFF_CNT_LOAD_EN
    logic [WIDTH-1:0] din_clamped;
    assign load_act    = Load;
    assign din_clamped = (cnt_t'(Din) > MOD_M1) ? MOD_M1_W : Din;
`else
    assign load_act    = 1'b0;
`endif

    assign cnt_nxt = next_count(cnt_t'(Q), Up, MOD_M1);

    always_comb begin
        q_next = Q;
        if (Clr) begin
            q_next = '0;
`ifdef TFF_CNT_LOAD_EN
        end else if (Load) begin
            q_next = din_clamped;
`endif
        end else if (En) begin
            q_next = cnt_nxt[WIDTH-1:0];
        end
    end

    // Gating with Reset_n keeps T and Tc quiet during reset; the stages
    // ignore T then anyway, but observers see a clean zero.
    assign T = Reset_n ? (Q ^ q_next) : '0;

    assign Tc = Reset_n & En & ~Clr & ~load_act &
                ((Up & (Q == MOD_M1_W)) | (~Up & (Q == '0)));

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_stage u_stage (
            .Clk     (Clk),
            .Reset_n (Reset_n),
            .T       (T[i]),
            .Q       (Q[i]),
            .Q_bar   (Q_bar[i])
        );
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Ovf <= 1'b0;
        end else if (Clr) begin
            Ovf <= 1'b0;
        end else if (Tc) begin
            Ovf <= 1'b1;
        end
    end

endmodule

// File: doc/tff_mod_counter.md
TFF_MOD_COUNTER -- requirements
Module: tff_mod_counter

Interface
- REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..16.
- REQ-002 Parameter MOD, default 10: count modulus; legal range 2..2**WIDTH.
- REQ-003 Port Clk, input, 1: single clock; all state changes on its rising edge.
- REQ-004 Port Reset_n, input, 1: reset, asynchronous, active-low.
- REQ-005 Port En, input, 1: count enable.
- REQ-006 Port Up, input, 1: direction; 1 = increment, 0 = decrement.
- REQ-007 Port Clr, input, 1: synchronous clear to zero.
- REQ-008 Port Load, input, 1: synchronous parallel load; present only with TFF_CNT_LOAD_EN.
- REQ-009 Port Din, input, WIDTH: load value; present only with TFF_CNT_LOAD_EN.
- REQ-010 Port Q, output, WIDTH: current count, registered.
- REQ-011 Port Q_bar, output, WIDTH: bitwise complement of Q at all times.
- REQ-012 Port T, output, WIDTH: per-bit toggle vector applied at the next edge (T[i]=1 means Q[i] flips); combinational.
- REQ-013 Port Tc, output, 1: terminal-count indication, combinational.
- REQ-014 Port Ovf, output, 1: sticky wrap flag, registered.

Function
- REQ-015 Every Q bit SHALL be held in a T-type storage stage; next state of bit i SHALL be Q[i] XOR T[i]; no other update path exists.
- REQ-016 T SHALL equal Q XOR Q_next, where Q_next is the value selected by the priority in REQ-017.
- REQ-017 Priority per edge: Clr > Load > En > hold.
- REQ-018 Clr=1: Q_next = 0, regardless of En, Load and Up.
- REQ-019 Load=1 (Clr=0): Q_next = Din when Din < MOD, else MOD-1 (clamp).
- REQ-020 En=1, Up=1: Q_next = Q+1, except at Q = MOD-1, where Q_next = 0.
- REQ-021 En=1, Up=0: Q_next = Q-1, except at Q = 0, where Q_next = MOD-1.
- REQ-022 En=0 with Clr=0 and Load=0: T = 0 and Q SHALL hold.
- REQ-023 Tc SHALL be 1 exactly when En=1, Clr=0, Load=0, and either (Up=1 and Q=MOD-1) or (Up=0 and Q=0).
- REQ-024 Ovf SHALL set to 1 on any edge where Tc=1 and SHALL hold until Clr=1 or reset; Clr takes priority over a simultaneous set.
- REQ-025 Latency: all inputs take effect at the first rising edge of Clk; Q, Ovf change only there.
- REQ-026 Q SHALL never leave 0..MOD-1 after reset. If Q ≥ MOD is ever observed, the next enabled edge SHALL force Q_next = 0 and SHALL NOT set Ovf.
- REQ-027 A direction change on any cycle SHALL take effect the same edge, with no dead cycle.

Reset
- REQ-028 Reset_n=0 SHALL immediately force Q=0, Q_bar=all ones and Ovf=0, independent of Clk.
- REQ-029 While Reset_n=0, T SHALL be 0 and Tc SHALL be 0.
- REQ-030 Reset asserted mid-count SHALL discard the pending update. The first edge after deassertion SHALL act normally from Q=0.

Configuration
- REQ-031 Macro TFF_CNT_LOAD_EN: when defined, Load and Din exist and REQ-019 applies.
- REQ-032 When TFF_CNT_LOAD_EN is undefined, Load and Din are absent and priority reduces to Clr > En > hold.

Structure
- REQ-033 Shared package tff_pkg SHALL hold the WIDTH and MOD defaults, the legal-range limits, and a function computing the next-count value from Q, Up and MOD.
- REQ-034 Sub-module tff_stage, one instance per bit, SHALL provide ports Clk, Reset_n, T, Q and Q_bar; it is the only storage for Q.
- REQ-035 Top level SHALL contain only next-value selection, T generation, Tc logic and the Ovf register.

Verification
- REQ-036 Reset: Reset_n=0 asynchronously mid-cycle with Q=7 -> Q=0, Q_bar=4'hF and Ovf=0 before the next edge.
- REQ-037 Up wrap (MOD=10): En=1, Up=1 for 12 edges from 0 -> Q runs 1..9, 0, 1, 2; Tc high only in the cycle when Q=9; Ovf=1 from edge 10 on.
- REQ-038 Down wrap: from Q=0, En=1, Up=0 -> Q=9, T=4'b1001, Ovf=1.
- REQ-039 Priority: Clr=1, Load=1, Din=5 and En=1 together at Q=4 with Ovf=1 -> Q=0 and Ovf=0; next edge with Load=1, Din=12 -> Q=9 (clamped).
- REQ-040 Hold/direction: En=0 for 5 edges at Q=3 -> Q=3 and T=0; then alternate Up each edge with En=1 -> Q sequence 4, 3, 4, 3.
- REQ-041 Build without TFF_CNT_LOAD_EN -> Load and Din ports are absent and REQ-037 still passes.
